// File: rtl/siso_chain_sequencer.sv
// siso_chain_sequencer: drives a 4-phase latch-based SISO chain from a
// valid/ready stream. Each step emits four non-overlapping latch pulses,
// starting on the output side, and shifts a shadow valid pipeline. The
// shadow pipeline tracks which chain slots hold real data.
module siso_chain_sequencer #(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int PW    = 1,
  parameter int GAP   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [LANES-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [3:0]                 latch,
  output logic [LANES-1:0]           siso_in,
  input  logic [LANES-1:0]           siso_out,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int SLOT  = PW + GAP;
  localparam int SUB_W = (SLOT > 1) ? $clog2(SLOT) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } state_t;

  state_t             state_r;
  logic [1:0]         phase_r;
  logic [SUB_W-1:0]   sub_r;
  logic [3:0]         latch_r;
  logic [LANES-1:0]   siso_in_r;
  logic [DEPTH-1:0]   sv_r;
  logic [OCC_W-1:0]   occ_r;
  logic               new_bit_r;
  logic               flush_active_r;

  logic               idle_s;
  logic               head_s;
  logic               in_ready_s;
  logic               out_valid_s;
  logic               push_s;
  logic               bubble_s;
  logic               pop_s;

  // One-hot latch pattern for a given phase.
  function automatic logic [3:0] phase_onehot(input logic [1:0] p);
    phase_onehot = 4'b0001 << p;
  endfunction

  // Handshake and step-start decode from the registered state.
  always_comb begin
    idle_s      = (state_r == ST_IDLE);
    head_s      = sv_r[DEPTH-1];
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    if (idle_s && !rst) begin
      in_ready_s  = !head_s;
      out_valid_s = head_s;
    end else begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
    end
    push_s   = in_valid && in_ready_s;
    pop_s    = out_valid_s && out_ready;
    bubble_s = idle_s && !rst && !push_s && flush_active_r &&
               (occ_r != {OCC_W{1'b0}}) && !head_s;
  end

  // Step FSM: pulse sequencing, data register, shadow valid and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      phase_r   <= 2'd0;
      sub_r     <= {SUB_W{1'b0}};
      latch_r   <= 4'b0000;
      siso_in_r <= {LANES{1'b0}};
      sv_r      <= {DEPTH{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      new_bit_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (push_s || bubble_s) begin
            state_r   <= ST_STEP;
            phase_r   <= 2'd0;
            sub_r     <= {SUB_W{1'b0}};
            latch_r   <= 4'b0001;
            siso_in_r <= push_s ? in_data : {LANES{1'b0}};
            new_bit_r <= push_s;
          end else if (pop_s) begin
            // Head leaves; a new step may only start next cycle.
            sv_r[DEPTH-1] <= 1'b0;
            occ_r         <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
            latch_r       <= 4'b0000;
          end else begin
            latch_r <= 4'b0000;
          end
        end
        ST_STEP: begin
          if (sub_r == SUB_W'(SLOT - 1)) begin
            if (phase_r == 2'd3) begin
              state_r <= ST_IDLE;
              latch_r <= 4'b0000;
              sv_r    <= {sv_r[DEPTH-2:0], new_bit_r};
              occ_r   <= occ_r + {{(OCC_W-1){1'b0}}, new_bit_r};
            end else begin
              phase_r <= phase_r + 2'd1;
              sub_r   <= {SUB_W{1'b0}};
              latch_r <= phase_onehot(phase_r + 2'd1);
            end
          end else begin
            sub_r <= sub_r + {{(SUB_W-1){1'b0}}, 1'b1};
            if ((int'(sub_r) + 1) < PW) begin
              latch_r <= phase_onehot(phase_r);
            end else begin
              latch_r <= 4'b0000;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          latch_r <= 4'b0000;
        end
      endcase
    end
  end

  // Flush request tracking; an empty chain with nothing in flight ignores it.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_active_r <= 1'b0;
    end else if (flush && ((occ_r != {OCC_W{1'b0}}) || (state_r == ST_STEP) || push_s)) begin
      flush_active_r <= 1'b1;
    end else if (idle_s && (occ_r == {OCC_W{1'b0}})) begin
      flush_active_r <= 1'b0;
    end else begin
      flush_active_r <= flush_active_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = siso_out;
  assign latch     = latch_r;
  assign siso_in   = siso_in_r;
  assign busy      = (state_r == ST_STEP);
  assign occupancy = occ_r;

endmodule

// File: tb/tb_siso_chain_sequencer.sv
// Directed bench for siso_chain_sequencer with DEPTH=4 and a behavioural
// chain that shifts one rank per step on the output-side pulse.
module tb_siso_chain_sequencer;

  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [LANES-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [3:0]       latch;
  logic [LANES-1:0] siso_in;
  logic [LANES-1:0] siso_out;
  logic             busy;
  logic [2:0]       occupancy;

  int total = 0;
  int bad   = 0;
  int ov_busy_cnt = 0;
  int multihot_cnt = 0;

  logic [LANES-1:0] chain [0:DEPTH-1];
  logic             l0_prev;

  siso_chain_sequencer #(.LANES(LANES), .DEPTH(DEPTH), .PW(1), .GAP(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .latch(latch), .siso_in(siso_in),
    .siso_out(siso_out), .busy(busy), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Behavioural chain: shift once per step when latch[0] rises.
  always @(posedge clk) begin
    if (rst) begin
      l0_prev <= 1'b0;
      for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
    end else begin
      l0_prev <= latch[0];
      if (latch[0] && !l0_prev) begin
        for (int i = DEPTH - 1; i > 0; i--) chain[i] <= chain[i-1];
        chain[0] <= siso_in;
      end
    end
  end
  assign siso_out = chain[DEPTH-1];

  // Global invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (out_valid && busy) ov_busy_cnt++;
    if ($countones(latch) > 1) multihot_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40 && busy; i++) tick;
    check_eq("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic push(input logic [LANES-1:0] d);
    for (int i = 0; i < 40 && !in_ready; i++) tick;
    check_eq("push_ready", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    in_data  = '0;
    check_eq("push_phase0", {28'd0, latch}, 32'h1);
    wait_idle;
  endtask

  logic [3:0] exp_pulse [8];
  int lat_act;
  int nb;
  int zb;
  int busy_cnt;

  initial begin
    exp_pulse = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick; tick;
    check_eq("rst_latch", {28'd0, latch}, 32'h0);
    check_eq("rst_occ", {29'd0, occupancy}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_siso_in", {28'd0, siso_in}, 32'h0);
    rst = 1'b0;
    tick;
    check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Pulse shape for one push of 0xA.
    in_data = 4'hA; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("pulse_%0d", k), {28'd0, latch}, {28'd0, exp_pulse[k]});
      if (k == 0) check_eq("pulse_siso_in", {28'd0, siso_in}, 32'hA);
      tick;
    end
    check_eq("pulse_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("pulse_busy", {31'd0, busy}, 32'd0);
    check_eq("pulse_occ", {29'd0, occupancy}, 32'd1);

    // Reset during phase 2, held for three cycles.
    in_data = 4'h7; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_data = '0;
    tick; tick; tick; tick;
    check_eq("mid_phase2", {28'd0, latch}, 32'h4);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check_eq("midrst_latch", {28'd0, latch}, 32'h0);
      check_eq("midrst_occ", {29'd0, occupancy}, 32'd0);
      check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    check_eq("midrst_sv", {28'd0, dut.sv_r}, 32'h0);
    rst = 1'b0;
    tick;
    check_eq("midrst_rel_ready", {31'd0, in_ready}, 32'd1);

    // Fill the four slots.
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    check_eq("fill_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("fill_out_data", {28'd0, out_data}, 32'h1);
    check_eq("fill_occ", {29'd0, occupancy}, 32'd4);
    check_eq("fill_in_ready", {31'd0, in_ready}, 32'd0);

    // Backpressure: head held, pending push must not step.
    in_data = 4'h9; in_valid = 1'b1; out_ready = 1'b0;
    lat_act = 0;
    for (int k = 0; k < 50; k++) begin
      tick;
      if (latch != 4'h0 || busy) lat_act++;
    end
    check_eq("bp_no_latch", lat_act, 32'd0);
    check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_eq("bp_xfer_occ", {29'd0, occupancy}, 32'd3);
    check_eq("bp_xfer_latch", {28'd0, latch}, 32'h0);
    check_eq("bp_xfer_ready", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0; in_data = '0;
    check_eq("bp_next_step", {28'd0, latch}, 32'h1);
    wait_idle;
    check_eq("bp_head_data", {28'd0, out_data}, 32'h2);
    check_eq("bp_occ", {29'd0, occupancy}, 32'd4);

    // Flush a single nibble out of an otherwise empty chain.
    rst = 1'b1; tick; rst = 1'b0; tick;
    push(4'h5);
    check_eq("fl_occ1", {29'd0, occupancy}, 32'd1);
    flush = 1'b1; tick; flush = 1'b0;
    nb = 0; zb = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      if (latch == 4'h1) begin
        nb++;
        if (siso_in != 4'h0) zb++;
      end
      tick;
    end
    check_eq("fl_bubbles", nb, 32'd3);
    check_eq("fl_bubble_zero", zb, 32'd0);
    check_eq("fl_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("fl_out_data", {28'd0, out_data}, 32'h5);
    out_ready = 1'b1; tick; out_ready = 1'b0;
    check_eq("fl_take_occ", {29'd0, occupancy}, 32'd0);
    check_eq("fl_take_ov", {31'd0, out_valid}, 32'd0);
    tick;
    check_eq("fl_active_clr", {31'd0, dut.flush_active_r}, 32'd0);
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (busy || latch != 4'h0) busy_cnt++;
    end
    check_eq("fl_quiet", busy_cnt, 32'd0);

    // Flush of an empty chain does nothing.
    flush = 1'b1; tick; flush = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (busy || latch != 4'h0) busy_cnt++;
    end
    check_eq("empty_flush_quiet", busy_cnt, 32'd0);
    check_eq("empty_flush_active", {31'd0, dut.flush_active_r}, 32'd0);

    check_eq("ov_while_busy", ov_busy_cnt, 32'd0);
    check_eq("latch_onehot", multihot_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/siso_chain_sequencer.md
# siso_chain_sequencer

Clocked controller that drives a 4-phase latch-based SISO chain (slice/tranche hierarchy, 4 lanes per rank) from a valid/ready stream. It generates the non-overlapping, flop-driven `latch[3:0]` pulse train for each shift step. It keeps a per-step shadow valid pipeline that tracks which chain slots hold real data, and presents the chain head as a valid/ready output. It also supports flushing bubbles so the last nibbles can be drained. It sits between the tile I/O logic and a chain instance, parametrised in lane width, depth in steps, and pulse timing.

## Interface
Parameters:
- `LANES`, 4, data width of one chain step (staggered lanes).
- `DEPTH`, 16, number of shift steps a nibble needs to travel from `siso_in` to `siso_out`; ≥2.
- `PW`, 1, clocks each latch pulse stays high; ≥1.
- `GAP`, 1, low clocks after each pulse (non-overlap guard); ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_data`  in  LANES  nibble to push.
- `in_valid`  in  1  push request.
- `in_ready`  out  1  push accepted when high together with `in_valid`.
- `out_data`  out  LANES  chain head, equal to `siso_out`.
- `out_valid`  out  1  head holds real data and the chain is stable.
- `out_ready`  in  1  consumer takes head.
- `flush`  in  1  one-cycle request to drain the chain with bubbles.
- `latch`  out  4  registered pulse outputs to the chain; bit 0 is the output-side rank.
- `siso_in`  out  LANES  registered data into the chain.
- `siso_out`  in  LANES  data from the chain.
- `busy`  out  1  step in progress.
- `occupancy`  out  $clog2(DEPTH+1)  count of valid slots.

## Operation
- State machine: IDLE → STEP → IDLE.
  - STEP contains phases 0..3 in order. Each phase is `PW` clocks with `latch[p]`=1, then `GAP` clocks with all latches at 0.
  - Phase order is output side first (bit 0 → bit 3), so bubbles propagate backwards.
- Shadow register `sv[DEPTH-1:0]` (flops) mirrors slot validity. `sv[DEPTH-1]` is the head.
- `in_ready` = IDLE && !`sv[DEPTH-1]` && !`rst`.
- `out_valid` = IDLE && `sv[DEPTH-1]`.
- Step start, evaluated in IDLE:
  - Push: `in_valid && in_ready` registers `in_data` into `siso_in`, new bit = 1.
  - Bubble: no push, `flush_active`, `occupancy`>0, and !`sv[DEPTH-1]`. `siso_in` is set to 0, new bit = 0.
  - Otherwise the block stays in IDLE and `latch` stays 0.
- At the last clock of a step: `sv <= {sv[DEPTH-2:0], new_bit}`.
- Output transfer (`out_valid && out_ready`): clears `sv[DEPTH-1]` and decrements `occupancy`. No step starts in the same cycle; the earliest start is the next cycle.
- `occupancy`: +1 when a push step completes, −1 on output transfer. It always equals popcount(`sv`).
- `flush` sets `flush_active`. `flush_active` clears when `occupancy` is 0 in IDLE. A `flush` while the chain is empty is a no-op. A push has priority over a bubble.
- `in_data` is ignored outside accepted cycles. `siso_in` holds its value between steps.
- Reset: `latch`=0, `siso_in`=0, `sv`=0, `occupancy`=0, `flush_active`=0, state IDLE, `busy`=0, `out_valid`=0, `in_ready`=0 while `rst` is high.
- Reset mid-step: `latch` is 0 at the next edge and the step is aborted. Chain contents are treated as invalid.

## Timing
- `T` = 4·(`PW`+`GAP`) clocks per step. Accept or bubble decision at edge t; STEP occupies cycles t+1..t+T; IDLE at t+T+1.
- `latch[p]` is high on cycles t+1+p·(`PW`+`GAP`) .. t+p·(`PW`+`GAP`)+`PW`.
- At most one `latch` bit is high in any cycle. Every bit is driven directly from a flop, with no combinational gating.
- Throughput: one nibble per `T`+1 clocks.
- Latency: a nibble is valid at `out_valid` after `DEPTH` completed steps from its own push step, counting pushes and bubbles.
- `out_valid` is never high while `busy` is high.

## Test plan
- Reset: hold `rst` 3 cycles mid-activity → `latch`=0000, `occupancy`=0, `out_valid`=0, `in_ready`=0. One cycle after release, `in_ready`=1.
- Pulse shape (`DEPTH`=4, `PW`=1, `GAP`=1): push 0xA at t → `latch` reads 0001,0000,0010,0000,0100,0000,1000,0000 on cycles t+1..t+8, and `in_ready`=1 at t+9.
- Fill (`DEPTH`=4): push 1,2,3,4 back-to-back with a behavioural chain model → after the 4th step, `out_valid`=1 with `out_data`=1. `in_ready`=0 until the head is taken. `occupancy`=4.
- Flush: push only 0x5, then pulse `flush` → 3 bubble steps with `siso_in`=0, `out_valid`=1 with 0x5. After the take, `occupancy`=0, `flush_active`=0, and no further steps run.
- Backpressure: keep `out_ready`=0 with `in_valid`=1 while the head is valid for 50 cycles → no `latch` activity. Raising `out_ready` → transfer, then the next step starts the cycle after.
- Reset mid-step: assert `rst` during phase 2 → `latch`=0 next cycle and `sv`=0. The next push starts a clean phase-0 sequence.
